sandbox_dispatch: RTL and testbench

//  Host-command front end for N_ENG sandboxed engines. Sits between the host link receiver/transmitter
//  (dataReceived/clearDR, transmitData) and the engines. Decodes opcode and channel from control,

---
 rtl/sandbox_pkg.sv | 30 +++
 rtl/sandbox_indicator.sv | 36 +++
 rtl/sandbox_dispatch.sv | 141 ++++++++++++++
 tb/tb_sandbox_dispatch.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sandbox_pkg.sv
// sandbox_pkg: opcodes, status bit indices and FSM encodings shared by the sandbox dispatch block
package sandbox_pkg;
   localparam logic [1:0] OP_QUERY  = 2'b00;
   localparam logic [1:0] OP_START  = 2'b01;
   localparam logic [1:0] OP_RESULT = 2'b10;
   localparam logic [1:0] OP_ABORT  = 2'b11;
   localparam int ST_OK      = 0;
   localparam int ST_DIDRUN  = 1;
   localparam int ST_SUCCESS = 2;
   localparam int ST_BUSY    = 3;
   localparam int ST_BADCH   = 4;
   localparam int ST_TIMEOUT = 5;
   localparam int ST_OP      = 6;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EXEC   = 3'd1,
      S_XMIT   = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4,
      S_WAITLO = 3'd5
   } stateT;
   // bit 2 of the indicator state is the LED itself
   typedef enum logic [2:0] {
      IND_IDLE  = 3'b000,
      IND_RISE1 = 3'b001,
      IND_FALL1 = 3'b010,
      IND_RISE2 = 3'b101,
      IND_FALL2 = 3'b110
   } indStateT;
endpackage

// File: rtl/sandbox_indicator.sv
// sandbox_indicator: stretches a start pulse into one full slowClock period on the LED
module sandbox_indicator
   import sandbox_pkg::*;
(
   input  logic masterClock,
   input  logic reset,
   input  logic slowClock,
   input  logic trigger,
   output logic led
);
   indStateT state, nextState;
   logic [2:0] slowSync;
   logic rise, fall;
   assign rise = slowSync[1] & ~slowSync[2];
   assign fall = ~slowSync[1] & slowSync[2];
   assign led  = state[2];
   always_ff @(posedge masterClock)
      if (reset) begin
         state    <= IND_IDLE;
         slowSync <= '0;
      end else begin
         state    <= nextState;
         slowSync <= {slowSync[1:0], slowClock};
      end
   always_comb begin
      nextState = state;
      case (state)
         IND_IDLE:  nextState = trigger ? IND_RISE1 : IND_IDLE;
         IND_RISE1: nextState = rise ? IND_FALL1 : IND_RISE1;
         IND_FALL1: nextState = fall ? IND_RISE2 : IND_FALL1;
         IND_RISE2: nextState = rise ? IND_FALL2 : IND_RISE2;
         IND_FALL2: nextState = fall ? IND_IDLE : IND_FALL2;
         default:   nextState = IND_IDLE;
      endcase
   end
endmodule

// File: rtl/sandbox_dispatch.sv
// sandbox_dispatch: host command front end for N_ENG engines; SANDBOX_WATCHDOG_EN adds busy timeouts
module sandbox_dispatch
   import sandbox_pkg::*;
#(
   parameter int N_ENG   = 4,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1000000
) (
   input  logic                      masterClock,
   input  logic                      reset,
   input  logic                      slowClock,
   input  logic                      dataReceived,
   input  logic [7:0]                control,
   input  logic [DATA_W-1:0]         inputData,
   output logic                      clearDR,
   output logic                      transmitData,
   output logic [7:0]                status,
   output logic [DATA_W-1:0]         outputData,
   output logic                      rxIndicator,
   output logic [N_ENG-1:0]          engStart,
   output logic [DATA_W-1:0]         engArg,
   input  logic [N_ENG-1:0]          engBusy,
   input  logic [N_ENG-1:0]          engDidRun,
   input  logic [N_ENG-1:0]          engSuccess,
   input  logic [N_ENG*DATA_W-1:0]   engResult
);
   stateT state, nextState;
   logic [7:0] ctlQ, stNext;
   logic [DATA_W-1:0] argQ, dataNext;
   logic [DATA_W-1:0] resultArr [16];
   logic [15:0] busyX, didRunX, successX, timedOut;
   logic [1:0] op;
   logic [3:0] ch;
   logic chOk, busyBit, startOk, unusedBits;
   assign op         = ctlQ[1:0];
   assign ch         = ctlQ[7:4];
   assign unusedBits = ^ctlQ[3:2];
   assign busyX      = 16'(engBusy);
   assign didRunX    = 16'(engDidRun);
   assign successX   = 16'(engSuccess);
   assign chOk       = {28'd0, ch} < 32'(N_ENG);
   assign busyBit    = chOk & busyX[ch];
   assign startOk    = op == OP_START && chOk && !busyBit;
   // unused channel slots read as zero so any 4-bit channel can index safely
   for (genvar c = 0; c < 16; c++) begin : gRes
      if (c < N_ENG) begin : gUse
         assign resultArr[c] = engResult[c*DATA_W +: DATA_W];
      end else begin : gZero
         assign resultArr[c] = '0;
      end
   end
`ifdef SANDBOX_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic abortClr;
   assign abortClr = state == S_EXEC && op == OP_ABORT;
   for (genvar c = 0; c < 16; c++) begin : gDog
      if (c < N_ENG) begin : gCnt
         logic [CW-1:0] count;
         logic expired;
         always_ff @(posedge masterClock)
            if (reset) begin
               count   <= '0;
               expired <= 1'b0;
            end else begin
               count   <= !engBusy[c] ? '0 : count == CW'(TIMEOUT) ? count : count + CW'(1);
               expired <= abortClr ? 1'b0 : (engBusy[c] && count == CW'(TIMEOUT - 1)) ? 1'b1 : expired;
            end
         assign timedOut[c] = expired;
      end else begin : gNone
         assign timedOut[c] = 1'b0;
      end
   end
`else
   logic unusedTimeout;
   assign unusedTimeout = |32'(TIMEOUT);
   assign timedOut      = '0;
`endif
   always_comb begin
      stNext             = '0;
      stNext[ST_OK]      = chOk && (op != OP_START || !busyBit);
      stNext[ST_DIDRUN]  = chOk & didRunX[ch];
      stNext[ST_SUCCESS] = chOk & successX[ch];
      stNext[ST_BUSY]    = busyBit;
      stNext[ST_BADCH]   = !chOk;
      stNext[ST_TIMEOUT] = chOk & timedOut[ch];
      stNext[ST_OP +: 2] = op;
      dataNext           = (op == OP_RESULT && chOk) ? resultArr[ch] : '0;
   end
   always_comb begin
      nextState = state;
      case (state)
         S_IDLE:   nextState = dataReceived ? S_EXEC : S_IDLE;
         S_EXEC:   nextState = S_XMIT;
         S_XMIT:   nextState = S_HOLD;
         S_HOLD:   nextState = S_DONE;
         S_DONE:   nextState = S_WAITLO;
         S_WAITLO: nextState = dataReceived ? S_WAITLO : S_IDLE;
         default:  nextState = S_IDLE;
      endcase
   end
   always_ff @(posedge masterClock)
      if (reset) begin
         state        <= S_IDLE;
         ctlQ         <= '0;
         argQ         <= '0;
         clearDR      <= 1'b0;
         transmitData <= 1'b0;
         status       <= 8'h00;
         outputData   <= '0;
         engStart     <= '0;
         engArg       <= '0;
      end else begin
         state    <= nextState;
         engStart <= '0;
         if (state == S_IDLE && dataReceived) begin
            ctlQ <= control;
            argQ <= inputData;
         end
         if (state == S_EXEC) begin
            status     <= stNext;
            outputData <= dataNext;
            if (startOk) begin
               engStart <= N_ENG'(1) << ch;
               engArg   <= argQ;
            end
         end
         if (state == S_XMIT) transmitData <= 1'b1;
         if (state == S_DONE) clearDR <= 1'b1;
         if (state == S_WAITLO && !dataReceived) begin
            transmitData <= 1'b0;
            clearDR      <= 1'b0;
         end
      end
   sandbox_indicator uIndicator (
      .masterClock (masterClock),
      .reset       (reset),
      .slowClock   (slowClock),
      .trigger     (state == S_EXEC && startOk),
      .led         (rxIndicator)
   );
endmodule

// File: tb/tb_sandbox_dispatch.sv
// tb_sandbox_dispatch: directed checks of command timing, status decoding, indicator and watchdog
module tb_sandbox_dispatch;
   logic masterClock = 1'b0;
   logic reset = 1'b1;
   logic slowClock = 1'b0;
   logic dataReceived = 1'b0;
   logic [7:0] control = 8'h00;
   logic [31:0] inputData = '0;
   logic clearDR, transmitData, rxIndicator;
   logic [7:0] status;
   logic [31:0] outputData, engArg;
   logic [3:0] engStart;
   logic [3:0] engBusy = '0;
   logic [3:0] engDidRun = '0;
   logic [3:0] engSuccess = '0;
   logic [127:0] engResult = '0;
   logic [3:0] seenStart;
   int passed = 0;
   int failed = 0;
   int total = 0;
   logic [7:0] expTo;
   sandbox_dispatch #(.N_ENG(4), .DATA_W(32), .TIMEOUT(8)) dut (
      .masterClock  (masterClock),
      .reset        (reset),
      .slowClock    (slowClock),
      .dataReceived (dataReceived),
      .control      (control),
      .inputData    (inputData),
      .clearDR      (clearDR),
      .transmitData (transmitData),
      .status       (status),
      .outputData   (outputData),
      .rxIndicator  (rxIndicator),
      .engStart     (engStart),
      .engArg       (engArg),
      .engBusy      (engBusy),
      .engDidRun    (engDidRun),
      .engSuccess   (engSuccess),
      .engResult    (engResult)
   );
   always #5 masterClock = ~masterClock;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cycles(input int n);
      repeat (n) @(negedge masterClock);
   endtask
   // full handshake: raise request, wait (bounded) for clearDR, release, confirm both lines drop
   task automatic runCmd(input string tag, input logic [7:0] ctl, input logic [31:0] arg);
      int n;
      n = 0;
      control = ctl;
      inputData = arg;
      dataReceived = 1'b1;
      seenStart = '0;
      while (!clearDR && n < 50) begin
         @(negedge masterClock);
         seenStart |= engStart;
         n++;
      end
      check({tag, " clearDR"}, 64'(clearDR), 64'(1));
      dataReceived = 1'b0;
      @(negedge masterClock);
      check({tag, " release"}, 64'({transmitData, clearDR}), 64'(0));
   endtask
   initial begin
`ifdef SANDBOX_WATCHDOG_EN
      expTo = 8'h20;
`else
      expTo = 8'h00;
`endif
      engResult = {32'h4444_0003, 32'hCAFE_0002, 32'h2222_0001, 32'h1111_0000};
      cycles(2);
      check("reset ctl", 64'({clearDR, transmitData, rxIndicator}), 64'(0));
      check("reset status", 64'(status), 64'(0));
      check("reset data", {outputData, engArg}, 64'(0));
      check("reset start", 64'(engStart), 64'(0));
      reset = 1'b0;
      cycles(1);
      control = 8'h11;
      inputData = 32'hDEAD_BEEF;
      dataReceived = 1'b1;
      cycles(1);
      check("start t", 64'({engStart, transmitData}), 64'(0));
      cycles(1);
      check("start t+1 pulse", 64'(engStart), 64'(4'b0010));
      check("start t+1 arg", 64'(engArg), 64'(32'hDEAD_BEEF));
      check("start t+1 status", 64'(status), 64'(8'h41));
      check("start t+1 tx", 64'(transmitData), 64'(0));
      cycles(1);
      check("start t+2 pulse", 64'(engStart), 64'(0));
      check("start t+2 tx/clr", 64'({transmitData, clearDR}), 64'(2'b10));
      cycles(1);
      check("start t+3 tx/clr", 64'({transmitData, clearDR}), 64'(2'b10));
      cycles(1);
      check("start t+4 tx/clr", 64'({transmitData, clearDR}), 64'(2'b11));
      cycles(20);
      check("hold high", 64'({transmitData, clearDR}), 64'(2'b11));
      dataReceived = 1'b0;
      cycles(1);
      check("hold drop", 64'({transmitData, clearDR}), 64'(0));
      check("status kept", 64'(status), 64'(8'h41));
      cycles(4);
      check("led before rise", 64'(rxIndicator), 64'(0));
      slowClock = 1'b1;
      cycles(4);
      check("led after rise", 64'(rxIndicator), 64'(0));
      slowClock = 1'b0;
      cycles(4);
      check("led on", 64'(rxIndicator), 64'(1));
      slowClock = 1'b1;
      cycles(4);
      check("led still on", 64'(rxIndicator), 64'(1));
      slowClock = 1'b0;
      cycles(4);
      check("led off", 64'(rxIndicator), 64'(0));
      engBusy = 4'b0010;
      runCmd("busy start", 8'h11, 32'h0000_1234);
      engBusy = 4'b0000;
      check("busy no pulse", 64'(seenStart), 64'(0));
      check("busy status", 64'(status), 64'(8'h48));
      check("busy arg kept", 64'(engArg), 64'(32'hDEAD_BEEF));
      cycles(4);
      runCmd("result ch2", 8'h22, 32'h0);
      check("result ch2 data", 64'(outputData), 64'(32'hCAFE_0002));
      runCmd("bad ch", 8'h72, 32'h0);
      check("bad ch status", 64'(status), 64'(8'h90));
      check("bad ch data", 64'(outputData), 64'(0));
      engDidRun = 4'b0100;
      engSuccess = 4'b0100;
      runCmd("result ch2b", 8'h22, 32'h0);
      check("result ch2 status", 64'(status), 64'(8'h87));
      engDidRun = 4'b0010;
      engSuccess = 4'b0000;
      engBusy = 4'b0010;
      runCmd("query ch1", 8'h10, 32'h0);
      engBusy = 4'b0000;
      check("query ch1 status", 64'(status), 64'(8'h0B));
      check("query ch1 data", 64'(outputData), 64'(0));
      engDidRun = 4'b0000;
      engBusy = 4'b0001;
      cycles(7);
      engBusy = 4'b0000;
      runCmd("query 7 busy", 8'h00, 32'h0);
      check("no timeout at 7", 64'(status), 64'(8'h01));
      engBusy = 4'b0001;
      cycles(8);
      engBusy = 4'b0000;
      runCmd("query 8 busy", 8'h00, 32'h0);
      check("timeout at 8", 64'(status), 64'(8'h01 | expTo));
      runCmd("abort", 8'h03, 32'h0);
      runCmd("query after abort", 8'h00, 32'h0);
      check("timeout cleared", 64'(status), 64'(8'h01));
      control = 8'h21;
      inputData = 32'h0BAD_F00D;
      dataReceived = 1'b1;
      cycles(6);
      check("waitlo reached", 64'({transmitData, clearDR}), 64'(2'b11));
      reset = 1'b1;
      cycles(1);
      check("mid reset ctl", 64'({transmitData, clearDR}), 64'(0));
      check("mid reset status", 64'(status), 64'(0));
      check("mid reset arg", 64'(engArg), 64'(0));
      dataReceived = 1'b0;
      reset = 1'b0;
      cycles(1);
      runCmd("post reset", 8'h32, 32'h0);
      check("post reset data", 64'(outputData), 64'(32'h4444_0003));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
